display_scan_ctrl: RTL

Scan controller for the five-digit multiplexed seven-segment display of the slot machine. It holds a shadow and an active digit bank written by the MCU-facing logic, and sequences the digit anodes one at a time. A blanking interval precedes each digit to suppress ghosting. Bank commits are applied only at frame boundaries so the reels never show a torn frame.

---
 rtl/display_scan_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Scan controller for a multiplexed seven-segment display. The MCU side writes
// digit codes into a shadow bank. A commit request copies the shadow bank into
// the active bank, but only on a frame wrap, so a frame is never torn. Every
// digit slot starts with a blanking interval (anodes and segments off) to
// suppress ghosting, followed by the ON portion where the digit is driven.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   wr_en          write strobe into the shadow bank
//   wr_addr        digit index for a write; indices >= NUM_DIGITS are dropped
//   wr_data        {blank, hex[3:0]}; blank=1 keeps the digit dark
//   commit_req     one-cycle request to copy shadow -> active at the next wrap
//   commit_pending a commit has been requested and not yet applied
//   commit_done    one-cycle pulse in the first cycle the new active bank holds
//   frame_tick     one-cycle pulse in the last displayed cycle of the frame
//   digit_sel      slot index matching the anode_n/seg_n currently driven
//   anode_n        active-low one-hot digit enable
//   seg_n          active-low segments {g,f,e,d,c,b,a}
//   dbg_state      slot phase FSM state (0 = BLANK, 1 = ON)
//
// Output timing: every output is a register. anode_n/seg_n/digit_sel show the
// slot position held by the counters in the previous cycle, so the display
// trails the counters by exactly one cycle. frame_tick and commit_done are
// registered from the wrap cycle and therefore line up with the last displayed
// cycle of the final digit.
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int NUM_DIGITS       = 5,
    parameter int CYCLES_PER_DIGIT = 83333,
    parameter int BLANK_CYCLES     = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [4:0]            wr_data,
    input  logic                  commit_req,
    output logic                  commit_pending,
    output logic                  commit_done,
    output logic                  frame_tick,
    output logic [2:0]            digit_sel,
    output logic [NUM_DIGITS-1:0] anode_n,
    output logic [6:0]            seg_n,
    output logic                  dbg_state
);

    localparam int             CW          = (CYCLES_PER_DIGIT > 1) ? $clog2(CYCLES_PER_DIGIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST    = CW'(CYCLES_PER_DIGIT - 1);
    localparam logic [CW-1:0]  CNT_BLANK   = CW'(BLANK_CYCLES);
    localparam logic [2:0]     SLOT_LAST   = 3'(NUM_DIGITS - 1);
    localparam logic [4:0]     BLANK_ENTRY = 5'b10000;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    // Slot position and phase
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    slot;
    logic [2:0]    slot_next;
    state_t        state;
    state_t        state_next;
    logic          slot_end;
    logic          frame_wrap;

    // Digit banks
    logic [4:0] shadow [NUM_DIGITS];
    logic [4:0] active [NUM_DIGITS];

    // Next values for the registered outputs
    logic [NUM_DIGITS-1:0] anode_next;
    logic [6:0]            seg_next;
    logic [4:0]            cur_entry;
    logic                  do_commit;
    logic                  wr_ok;

    // Active-high gfedcba pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Slot counter and BLANK/ON phase FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        slot_end   = (cnt == CNT_LAST);
        frame_wrap = slot_end && (slot == SLOT_LAST);
        cnt_next   = slot_end ? '0 : cnt + CW'(1);
        slot_next  = slot;
        if (slot_end) begin
            slot_next = (slot == SLOT_LAST) ? 3'd0 : slot + 3'd1;
        end
        // The phase is a pure function of where the counter lands next, so the
        // state register always agrees with cnt.
        state_next = (cnt_next < CNT_BLANK) ? ST_BLANK : ST_ON;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            slot  <= 3'd0;
            state <= ST_BLANK;
        end else begin
            cnt   <= cnt_next;
            slot  <= slot_next;
            state <= state_next;
        end
    end

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Output decode for the position held in the counters this cycle
    // ------------------------------------------------------------------
    always_comb begin
        anode_next = '1;
        seg_next   = '1;
        cur_entry  = active[slot];
        if (state == ST_ON) begin
            anode_next[slot] = 1'b0;
            // A blanked digit keeps its anode enabled but lights no segment.
            if (!cur_entry[4]) begin
                seg_next = ~hex_to_seg(cur_entry[3:0]);
            end
        end
    end

    // A request arriving on the wrap cycle itself is honoured on that wrap.
    assign do_commit = frame_wrap && (commit_pending || commit_req);
    assign wr_ok     = wr_en && ({29'd0, wr_addr} < 32'(NUM_DIGITS));

    // ------------------------------------------------------------------
    // Banks, commit handshake and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            anode_n        <= '1;
            seg_n          <= '1;
            digit_sel      <= 3'd0;
            frame_tick     <= 1'b0;
            commit_done    <= 1'b0;
            commit_pending <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= BLANK_ENTRY;
                active[i] <= BLANK_ENTRY;
            end
        end else begin
            anode_n     <= anode_next;
            seg_n       <= seg_next;
            digit_sel   <= slot;
            frame_tick  <= frame_wrap;
            commit_done <= do_commit;

            if (do_commit) begin
                // Non-blocking copy takes the shadow contents from before any
                // write landing on this same edge.
                active         <= shadow;
                commit_pending <= 1'b0;
            end else if (commit_req) begin
                commit_pending <= 1'b1;
            end

            if (wr_ok) begin
                shadow[wr_addr] <= wr_data;
            end
        end
    end

endmodule
